// File: rtl/fsic_io_serdes_pkg.sv
// Shared definitions for the IO SERDES control/status register block.
// Register DW offsets, CTRL/STATUS bit positions and the lane-enable reset value.
// Imported by the CSR top; holds no logic.
package fsic_io_serdes_pkg;

    // DW offsets within the CSR window
    localparam int unsigned OFS_CTRL    = 0;
    localparam int unsigned OFS_LANE_EN = 1;
    localparam int unsigned OFS_STATUS  = 2;
    localparam int unsigned OFS_ERRCNT  = 3;

    // CTRL register bit positions
    localparam int CTRL_RXEN_BIT     = 0;
    localparam int CTRL_TXEN_BIT     = 1;
    localparam int CTRL_LOOPBACK_BIT = 2;
    localparam int CTRL_WIDTH        = 3;

    // STATUS register bit positions
    localparam int STS_TXEN_BIT  = 0;
    localparam int STS_RXRCV_BIT = 1;

    // Every lane comes out of reset enabled; replicated to the lane count
    localparam logic LANE_EN_RST_BIT = 1'b1;

endpackage

// File: rtl/fsic_sync_2ff.sv
// Multi-stage flop synchroniser for slow level/toggle signals from another clock domain.
// Latency: pSTAGES destination-clock edges.
// No backpressure; samples every cycle.
module fsic_sync_2ff #(
    parameter int pSTAGES = 2,
    parameter int pWIDTH  = 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [pWIDTH-1:0] d_i,
    output logic [pWIDTH-1:0] q_o
);

    logic [pWIDTH-1:0] sync_q [pSTAGES];

    // shift the asynchronous input through the flop chain
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < pSTAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < pSTAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign q_o = sync_q[pSTAGES-1];

endmodule

// File: rtl/fsic_io_serdes_csr.sv
// AXI-Lite CSR block for the IO SERDES: CTRL, LANE_EN, STATUS and (with FSIC_SERDES_CSR_ERRCNT_EN) ERRCNT.
// Latency: write bvalid 2 cycles after joint AW/W acceptance; read rvalid 1 cycle after AR acceptance.
// Backpressure: one write held until bready, one read held until rready; cc_ls_enable=0 blocks new requests.
module fsic_io_serdes_csr
    import fsic_io_serdes_pkg::*;
#(
    parameter int pADDR_WIDTH     = 10,
    parameter int pDATA_WIDTH     = 32,
    parameter int pSERIALIO_WIDTH = 12,
    parameter int pERRCNT_WIDTH   = 16
) (
    input  logic                       axi_clk,
    input  logic                       axi_reset_n,
    input  logic                       cc_ls_enable,
    input  logic                       axi_awvalid,
    output logic                       axi_awready,
    input  logic [pADDR_WIDTH-1:0]     axi_awaddr,
    input  logic                       axi_wvalid,
    output logic                       axi_wready,
    input  logic [pDATA_WIDTH-1:0]     axi_wdata,
    input  logic [pDATA_WIDTH/8-1:0]   axi_wstrb,
    output logic                       axi_bvalid,
    input  logic                       axi_bready,
    input  logic                       axi_arvalid,
    output logic                       axi_arready,
    input  logic [pADDR_WIDTH-1:0]     axi_araddr,
    output logic                       axi_rvalid,
    output logic [pDATA_WIDTH-1:0]     axi_rdata,
    input  logic                       axi_rready,
    output logic                       rxen_ctl,
    output logic                       txen_ctl,
    output logic                       loopback_ctl,
    output logic [pSERIALIO_WIDTH-1:0] lane_en,
    input  logic                       txen_sts,
    input  logic                       rx_received_sts,
    input  logic                       err_toggle
);

    logic                       aw_held_q, w_held_q, bvalid_q, rvalid_q;
    logic [pADDR_WIDTH-1:0]     awaddr_q;
    logic [pDATA_WIDTH-1:0]     wdata_q, rdata_q, rdata_d, errcnt_rd;
    logic [pDATA_WIDTH/8-1:0]   wstrb_q;
    logic [CTRL_WIDTH-1:0]      ctrl_q, ctrl_d;
    logic [pSERIALIO_WIDTH-1:0] lane_en_q, lane_en_d;
    logic [1:0]                 sts_s;
    logic                       aw_acc, w_acc, ar_acc, commit;
    logic                       unused_bits;

    assign aw_acc = axi_awvalid & cc_ls_enable & ~aw_held_q;
    assign w_acc  = axi_wvalid  & cc_ls_enable & ~w_held_q;
    assign ar_acc = axi_arvalid & cc_ls_enable & ~rvalid_q;
    // one write in flight: a new commit waits until the previous response is taken
    assign commit = aw_held_q & w_held_q & ~bvalid_q;

    // AXI handshake state: holding regs, write response, registered read data
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            if (commit) begin
                aw_held_q <= 1'b0;
            end else if (aw_acc) begin
                aw_held_q <= 1'b1;
                awaddr_q  <= axi_awaddr;
            end
            if (commit) begin
                w_held_q <= 1'b0;
            end else if (w_acc) begin
                w_held_q <= 1'b1;
                wdata_q  <= axi_wdata;
                wstrb_q  <= axi_wstrb;
            end
            if (commit) begin
                bvalid_q <= 1'b1;
            end else if (axi_bready) begin
                bvalid_q <= 1'b0;
            end
            if (ar_acc) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rdata_d;
            end else if (axi_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // next-state for the RW registers on a committed write
    always_comb begin
        ctrl_d    = ctrl_q;
        lane_en_d = lane_en_q;
        if (commit && awaddr_q == pADDR_WIDTH'(OFS_CTRL) && wstrb_q[0]) begin
            ctrl_d = wdata_q[CTRL_WIDTH-1:0];
        end
        if (commit && awaddr_q == pADDR_WIDTH'(OFS_LANE_EN)) begin
            for (int i = 0; i < pSERIALIO_WIDTH; i++) begin
                if (wstrb_q[i/8]) lane_en_d[i] = wdata_q[i];
            end
        end
    end

    // RW register state
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            ctrl_q    <= '0;
            lane_en_q <= {pSERIALIO_WIDTH{LANE_EN_RST_BIT}};
        end else begin
            ctrl_q    <= ctrl_d;
            lane_en_q <= lane_en_d;
        end
    end

    fsic_sync_2ff #(.pSTAGES(2), .pWIDTH(2)) u_sts_sync (
        .clk_i   (axi_clk),
        .rst_n_i (axi_reset_n),
        .d_i     ({rx_received_sts, txen_sts}),
        .q_o     (sts_s)
    );

`ifdef FSIC_SERDES_CSR_ERRCNT_EN
    logic                     err_s, err_prev_q, err_inc, err_clr;
    logic [pERRCNT_WIDTH-1:0] errcnt_q, errcnt_d;

    fsic_sync_2ff #(.pSTAGES(3), .pWIDTH(1)) u_err_sync (
        .clk_i   (axi_clk),
        .rst_n_i (axi_reset_n),
        .d_i     (err_toggle),
        .q_o     (err_s)
    );

    assign err_inc = err_s ^ err_prev_q;
    assign err_clr = commit & (awaddr_q == pADDR_WIDTH'(OFS_ERRCNT)) & wstrb_q[0];

    // saturating counter; a clear that coincides with an error keeps that error
    always_comb begin
        errcnt_d = errcnt_q;
        if (err_clr) begin
            errcnt_d = pERRCNT_WIDTH'(err_inc);
        end else if (err_inc && !(&errcnt_q)) begin
            errcnt_d = errcnt_q + 1'b1;
        end
    end

    // toggle edge-detect history and counter state
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            err_prev_q <= 1'b0;
            errcnt_q   <= '0;
        end else begin
            err_prev_q <= err_s;
            errcnt_q   <= errcnt_d;
        end
    end

    assign errcnt_rd   = pDATA_WIDTH'(errcnt_q);
    assign unused_bits = ^{wdata_q, wstrb_q};
`else
    assign errcnt_rd   = '0;
    assign unused_bits = ^{wdata_q, wstrb_q, err_toggle};
`endif

    // read mux, sampled at AR acceptance so a same-cycle write is not yet visible
    always_comb begin
        rdata_d = '0;
        if (axi_araddr == pADDR_WIDTH'(OFS_CTRL)) begin
            rdata_d[CTRL_WIDTH-1:0] = ctrl_q;
        end else if (axi_araddr == pADDR_WIDTH'(OFS_LANE_EN)) begin
            rdata_d[pSERIALIO_WIDTH-1:0] = lane_en_q;
        end else if (axi_araddr == pADDR_WIDTH'(OFS_STATUS)) begin
            rdata_d[STS_TXEN_BIT]  = sts_s[0];
            rdata_d[STS_RXRCV_BIT] = sts_s[1];
        end else if (axi_araddr == pADDR_WIDTH'(OFS_ERRCNT)) begin
            rdata_d = errcnt_rd;
        end
    end

    assign axi_awready  = ~aw_held_q;
    assign axi_wready   = ~w_held_q;
    assign axi_bvalid   = bvalid_q;
    assign axi_arready  = ~rvalid_q;
    assign axi_rvalid   = rvalid_q;
    assign axi_rdata    = rdata_q;
    assign rxen_ctl     = ctrl_q[CTRL_RXEN_BIT];
    assign txen_ctl     = ctrl_q[CTRL_TXEN_BIT];
    assign loopback_ctl = ctrl_q[CTRL_LOOPBACK_BIT];
    assign lane_en      = lane_en_q;

endmodule

// File: tb/tb_fsic_io_serdes_csr.sv
// Self-checking bench for fsic_io_serdes_csr: directed corner cases plus random AXI-Lite traffic.
// Expected register contents come from a behavioural model of the register map.
// Build with FSIC_SERDES_CSR_ERRCNT_EN to also exercise the error counter and its saturation.
module tb_fsic_io_serdes_csr;

    logic        axi_clk = 1'b0;
    logic        axi_reset_n;
    logic        cc_ls_enable;
    logic        axi_awvalid, axi_awready;
    logic [9:0]  axi_awaddr;
    logic        axi_wvalid, axi_wready;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_bvalid, axi_bready;
    logic        axi_arvalid, axi_arready;
    logic [9:0]  axi_araddr;
    logic        axi_rvalid;
    logic [31:0] axi_rdata;
    logic        axi_rready;
    logic        rxen_ctl, txen_ctl, loopback_ctl;
    logic [11:0] lane_en;
    logic        txen_sts, rx_received_sts, err_toggle;

    always #5 axi_clk = ~axi_clk;

    fsic_io_serdes_csr dut (
        .axi_clk(axi_clk), .axi_reset_n(axi_reset_n), .cc_ls_enable(cc_ls_enable),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
        .axi_rvalid(axi_rvalid), .axi_rdata(axi_rdata), .axi_rready(axi_rready),
        .rxen_ctl(rxen_ctl), .txen_ctl(txen_ctl), .loopback_ctl(loopback_ctl), .lane_en(lane_en),
        .txen_sts(txen_sts), .rx_received_sts(rx_received_sts), .err_toggle(err_toggle)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // reference model of the register map
    logic [2:0]  m_ctrl = 3'd0;
    logic [11:0] m_lane = 12'hFFF;
    logic        m_tx = 1'b0, m_rx = 1'b0;
    int          m_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] exp_read(input logic [9:0] a);
        case (a)
            10'd0:   return 32'(m_ctrl);
            10'd1:   return 32'(m_lane);
            10'd2:   return 32'({m_rx, m_tx});
            10'd3:   return 32'(m_err);
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] mask = 32'd0;
        for (int b = 0; b < 4; b++) if (s[b]) mask = mask | (32'hFF << (8 * b));
        if (a == 10'd0 && s[0]) m_ctrl = d[2:0];
        if (a == 10'd1) m_lane = 12'((32'(m_lane) & ~mask) | (d & mask));
`ifdef FSIC_SERDES_CSR_ERRCNT_EN
        if (a == 10'd3 && s[0]) m_err = 0;
`endif
    endtask

    task automatic chk_ctl(input string tag);
        chk({tag, "_ctl"}, 32'({loopback_ctl, txen_ctl, rxen_ctl}), 32'(m_ctrl));
        chk({tag, "_lane"}, 32'(lane_en), 32'(m_lane));
    endtask

    // AXI write; W is presented w_delay cycles after AW
    task automatic axi_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int w_delay);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        int nb = 0;
        @(negedge axi_clk);
        axi_awvalid = 1'b1; axi_awaddr = a; axi_wdata = d; axi_wstrb = s;
        for (int c = 0; c < 40 && !(aw_done && w_done); c++) begin
            if (c >= w_delay && !w_done) axi_wvalid = 1'b1;
            aw_hs = axi_awvalid && axi_awready;
            w_hs  = axi_wvalid && axi_wready;
            @(posedge axi_clk); @(negedge axi_clk);
            if (aw_hs) begin axi_awvalid = 1'b0; aw_done = 1; end
            if (w_hs)  begin axi_wvalid = 1'b0;  w_done = 1;  end
            if (aw_done && !w_done) begin
                chk("awready_while_held", 32'(axi_awready), 32'd0);
                chk("bvalid_before_w", 32'(axi_bvalid), 32'd0);
            end
        end
        axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        chk("write_accept", 32'({aw_done, w_done}), 32'd3);
        for (int c = 0; c < 8; c++) begin
            if (axi_bvalid) nb++;
            @(negedge axi_clk);
        end
        chk("bvalid_pulses", 32'(nb), 32'd1);
        model_write(a, d, s);
    endtask

    // AXI read with rready held low for 'hold' cycles after rvalid
    task automatic axi_read(input logic [9:0] a, input logic [31:0] exp, input int hold);
        bit ok = 0;
        @(negedge axi_clk);
        axi_arvalid = 1'b1; axi_araddr = a; axi_rready = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            ok = axi_arready;
            @(posedge axi_clk); @(negedge axi_clk);
        end
        axi_arvalid = 1'b0;
        chk("rvalid_after_ar", 32'(axi_rvalid), 32'd1);
        chk("rdata", axi_rdata, exp);
        for (int h = 0; h < hold; h++) begin
            @(posedge axi_clk); @(negedge axi_clk);
            chk("rvalid_hold", 32'(axi_rvalid), 32'd1);
            chk("arready_hold", 32'(axi_arready), 32'd0);
            chk("rdata_hold", axi_rdata, exp);
        end
        axi_rready = 1'b1;
        @(posedge axi_clk); @(negedge axi_clk);
        chk("rvalid_drop", 32'(axi_rvalid), 32'd0);
        chk("arready_back", 32'(axi_arready), 32'd1);
        axi_rready = 1'b0;
    endtask

    task automatic pulse_err(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge axi_clk);
            err_toggle = ~err_toggle;
        end
        repeat (6) @(negedge axi_clk);
`ifdef FSIC_SERDES_CSR_ERRCNT_EN
        m_err = (m_err + n > 65535) ? 65535 : m_err + n;
`endif
    endtask

    initial begin
        logic [11:0] old_lane;
        logic [9:0]  ra;
        logic [31:0] rd;
        axi_reset_n = 1'b0; cc_ls_enable = 1'b1;
        axi_awvalid = 0; axi_awaddr = 0; axi_wvalid = 0; axi_wdata = 0; axi_wstrb = 0;
        axi_bready = 1'b1; axi_arvalid = 0; axi_araddr = 0; axi_rready = 0;
        txen_sts = 0; rx_received_sts = 0; err_toggle = 0;
        repeat (3) @(negedge axi_clk);
        chk("rst_awready", 32'(axi_awready), 32'd1);
        chk("rst_wready", 32'(axi_wready), 32'd1);
        chk("rst_bvalid", 32'(axi_bvalid), 32'd0);
        chk("rst_arready", 32'(axi_arready), 32'd1);
        chk("rst_rvalid", 32'(axi_rvalid), 32'd0);
        chk("rst_rdata", axi_rdata, 32'd0);
        chk_ctl("rst");
        axi_reset_n = 1'b1;
        repeat (2) @(negedge axi_clk);

        // CTRL write with W trailing AW by 3 cycles
        axi_write(10'd0, 32'h7, 4'h1, 3);
        chk_ctl("ctrl_wr");
        axi_read(10'd0, exp_read(10'd0), 0);

        // LANE_EN byte strobes
        axi_write(10'd1, 32'h0000_0A5C, 4'h1, 0);
        chk("lane_strb0", 32'(lane_en), 32'h0F5C);
        axi_write(10'd1, 32'h0000_0A5C, 4'h2, 0);
        chk("lane_strb1", 32'(lane_en), 32'h0A5C);

        // STATUS read with read-data backpressure
        txen_sts = 1'b1; m_tx = 1'b1;
        repeat (4) @(negedge axi_clk);
        axi_read(10'd2, exp_read(10'd2), 5);

        // block disabled: nothing accepted
        @(negedge axi_clk);
        cc_ls_enable = 1'b0;
        axi_awvalid = 1; axi_wvalid = 1; axi_awaddr = 10'd0; axi_wdata = 32'h3; axi_wstrb = 4'h1;
        axi_arvalid = 1; axi_araddr = 10'd0;
        for (int c = 0; c < 5; c++) begin
            @(posedge axi_clk); @(negedge axi_clk);
            chk("dis_bvalid", 32'(axi_bvalid), 32'd0);
            chk("dis_rvalid", 32'(axi_rvalid), 32'd0);
        end
        axi_awvalid = 0; axi_wvalid = 0; axi_arvalid = 0;
        cc_ls_enable = 1'b1;
        repeat (3) @(negedge axi_clk);
        chk("dis_bvalid_after", 32'(axi_bvalid), 32'd0);
        chk_ctl("dis");

        // read accepted on the same edge the write commits returns the old value
        old_lane = m_lane;
        @(negedge axi_clk);
        axi_awvalid = 1; axi_wvalid = 1; axi_awaddr = 10'd1; axi_wdata = 32'h0000_0333; axi_wstrb = 4'h3;
        @(posedge axi_clk); @(negedge axi_clk);
        axi_awvalid = 0; axi_wvalid = 0;
        axi_arvalid = 1; axi_araddr = 10'd1;
        @(posedge axi_clk); @(negedge axi_clk);
        axi_arvalid = 0;
        chk("rw_same_rvalid", 32'(axi_rvalid), 32'd1);
        chk("rw_same_rdata", axi_rdata, 32'(old_lane));
        axi_rready = 1;
        @(posedge axi_clk); @(negedge axi_clk);
        axi_rready = 0;
        model_write(10'd1, 32'h0000_0333, 4'h3);
        repeat (2) @(negedge axi_clk);
        chk_ctl("rw_same");

        // error counter: three errors, then a clear coinciding with a fourth
        pulse_err(3);
        axi_read(10'd3, exp_read(10'd3), 0);
        @(negedge axi_clk);
        err_toggle = ~err_toggle;
        @(negedge axi_clk);
        @(negedge axi_clk);
        axi_awvalid = 1; axi_wvalid = 1; axi_awaddr = 10'd3; axi_wdata = 32'h0; axi_wstrb = 4'h1;
        @(posedge axi_clk); @(negedge axi_clk);
        axi_awvalid = 0; axi_wvalid = 0;
        repeat (6) @(negedge axi_clk);
`ifdef FSIC_SERDES_CSR_ERRCNT_EN
        m_err = 1;
`endif
        axi_read(10'd3, exp_read(10'd3), 0);
`ifdef FSIC_SERDES_CSR_ERRCNT_EN
        pulse_err(32'hFFFE - m_err);
        axi_read(10'd3, exp_read(10'd3), 0);
        pulse_err(3);
        axi_read(10'd3, exp_read(10'd3), 0);
`endif

        // random traffic against the model
        for (int i = 0; i < 40; i++) begin
            txen_sts = 1'($urandom); rx_received_sts = 1'($urandom);
            m_tx = txen_sts; m_rx = rx_received_sts;
            repeat (4) @(negedge axi_clk);
            ra = 10'($urandom_range(0, 7));
            if (ra == 10'd7) ra = 10'h200 | 10'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) begin
                axi_write(ra, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
                chk_ctl("rnd_wr");
            end else begin
                rd = exp_read(ra);
                axi_read(ra, rd, $urandom_range(0, 2));
            end
        end

        // asynchronous reset while a write response is pending
        @(negedge axi_clk);
        axi_bready = 1'b0;
        axi_awvalid = 1; axi_wvalid = 1; axi_awaddr = 10'd1; axi_wdata = 32'h123; axi_wstrb = 4'h3;
        axi_arvalid = 0;
        @(posedge axi_clk); @(negedge axi_clk);
        axi_awvalid = 0; axi_wvalid = 0;
        @(posedge axi_clk); @(negedge axi_clk);
        chk("pre_rst_bvalid", 32'(axi_bvalid), 32'd1);
        chk("pre_rst_lane", 32'(lane_en), 32'h123);
        #2 axi_reset_n = 1'b0;
        #1;
        m_ctrl = 3'd0; m_lane = 12'hFFF; m_err = 0;
        chk("arst_bvalid", 32'(axi_bvalid), 32'd0);
        chk("arst_awready", 32'(axi_awready), 32'd1);
        chk_ctl("arst");
        @(negedge axi_clk);
        axi_reset_n = 1'b1; axi_bready = 1'b1;
        repeat (4) @(negedge axi_clk);
        axi_read(10'd1, exp_read(10'd1), 0);
        axi_read(10'd0, exp_read(10'd0), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
